// File: rtl/seg_disp_seq.sv
// rtl/seg_disp_seq.sv - sequential multi-channel binary to seven-segment converter
module seg_disp_seq #(
    parameter int NUM_CH   = 3,
    parameter int IN_W     = 10,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                       CLOCK_50,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [NUM_CH*IN_W-1:0]     ch_val,
    input  logic [NUM_CH-1:0]          ch_en,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_CH*DIGITS*7-1:0] hex_out,
    output logic [NUM_CH-1:0]          overflow
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam int FLD_W = 7 * DIGITS;
    // Overflow threshold; values below 2**IN_W never reach it when it is out of range
    localparam logic [63:0] LIMIT = 64'(10) ** DIGITS;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_WRITE} state_t;

    state_t                      state_q, state_d;
    logic [NUM_CH*IN_W-1:0]      shadow_val_q, shadow_val_d;
    logic [NUM_CH-1:0]           shadow_en_q, shadow_en_d;
    logic [CH_W-1:0]             ch_idx_q, ch_idx_d;
    logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [IN_W-1:0]             bin_q, bin_d;
    logic [BCD_W-1:0]            bcd_q, bcd_d;
    logic [NUM_CH*FLD_W-1:0]     hex_q, hex_d;
    logic [NUM_CH-1:0]           ovf_q, ovf_d;
    logic                        done_q, done_d;

    logic [IN_W-1:0]             cur_val;
    logic [CH_W-1:0]             next_idx;
    logic [IN_W-1:0]             next_val;
    logic [BCD_W-1:0]            bcd_adj;
    logic [FLD_W-1:0]            field;
    logic                        field_ovf;
    logic                        lead_zero;
    logic [3:0]                  nib;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Add-3 correction of every BCD nibble ahead of the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
    end

    // Digit field for the channel being written: blank, dashes, or decoded digits
    always_comb begin
        cur_val   = shadow_val_q[ch_idx_q*IN_W +: IN_W];
        field     = '1;
        field_ovf = 1'b0;
        lead_zero = 1'b1;
        nib       = '0;
        if (!shadow_en_q[ch_idx_q]) begin
            field = '1;
        end else if (64'(cur_val) >= LIMIT) begin
            field_ovf = 1'b1;
            for (int d = 0; d < DIGITS; d++)
                field[7*d +: 7] = 7'b1111110;
        end else begin
            for (int d = DIGITS - 1; d >= 0; d--) begin
                nib = bcd_q[4*d +: 4];
                if (nib != 4'd0)
                    lead_zero = 1'b0;
                if (BLANK_LZ != 0 && lead_zero && d != 0)
                    field[7*d +: 7] = 7'b1111111;
                else
                    field[7*d +: 7] = seg7(nib);
            end
        end
    end

    // Next-state and datapath updates for the load/convert/write sequence
    always_comb begin
        state_d      = state_q;
        shadow_val_d = shadow_val_q;
        shadow_en_d  = shadow_en_q;
        ch_idx_d     = ch_idx_q;
        bit_cnt_d    = bit_cnt_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        hex_d        = hex_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;
        next_idx     = ch_idx_q + 1'b1;
        next_val     = shadow_val_q[next_idx*IN_W +: IN_W];
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    shadow_val_d = ch_val;
                    shadow_en_d  = ch_en;
                    ch_idx_d     = '0;
                    bit_cnt_d    = '0;
                    bin_d        = ch_val[IN_W-1:0];
                    bcd_d        = '0;
                    state_d      = ch_en[0] ? S_CONV : S_WRITE;
                end
            end
            S_CONV: begin
                bcd_d     = (bcd_adj << 1) | BCD_W'(bin_q[IN_W-1]);
                bin_d     = bin_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT)
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                hex_d[ch_idx_q*FLD_W +: FLD_W] = field;
                ovf_d[ch_idx_q]                = field_ovf;
                if (ch_idx_q == LAST_CH) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    ch_idx_d  = next_idx;
                    bit_cnt_d = '0;
                    bin_d     = next_val;
                    bcd_d     = '0;
                    state_d   = shadow_en_q[next_idx] ? S_CONV : S_WRITE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            shadow_val_q <= '0;
            shadow_en_q  <= '0;
            ch_idx_q     <= '0;
            bit_cnt_q    <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            hex_q        <= '1;
            ovf_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_val_q <= shadow_val_d;
            shadow_en_q  <= shadow_en_d;
            ch_idx_q     <= ch_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            hex_q        <= hex_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign hex_out  = hex_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg_disp_seq.sv
// tb/tb_seg_disp_seq.sv - scoreboard bench for seg_disp_seq
module tb_seg_disp_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, load;
    logic [29:0] ch_val;
    logic [2:0]  ch_en;
    logic        busy, done, busy_n, done_n, busy_2, done_2;
    logic [83:0] hex, hex_n;
    logic [41:0] hex_2;
    logic [2:0]  ovf, ovf_n, ovf_2;

    seg_disp_seq u_dut (
        .CLOCK_50(clk), .rst_n(rst_n), .load(load), .ch_val(ch_val), .ch_en(ch_en),
        .busy(busy), .done(done), .hex_out(hex), .overflow(ovf)
    );

    seg_disp_seq #(.BLANK_LZ(0)) u_nlz (
        .CLOCK_50(clk), .rst_n(rst_n), .load(load), .ch_val(ch_val), .ch_en(ch_en),
        .busy(busy_n), .done(done_n), .hex_out(hex_n), .overflow(ovf_n)
    );

    seg_disp_seq #(.DIGITS(2)) u_d2 (
        .CLOCK_50(clk), .rst_n(rst_n), .load(load), .ch_val(ch_val), .ch_en(ch_en),
        .busy(busy_2), .done(done_2), .hex_out(hex_2), .overflow(ovf_2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [83:0] hex;
        logic [2:0]  ovf;
        logic [83:0] hex_n;
        logic [41:0] hex_2;
        logic [2:0]  ovf_2;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [83:0] obs, input logic [83:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [6:0] seg(input int n);
        case (n)
            0: return 7'b0000001;  1: return 7'b1001111;
            2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] exp_field(input int val, input bit en, input int digits, input bit blz);
        logic [27:0] f;
        int pw;
        f = '1;
        if (!en) return f;
        if (val >= 10**digits) begin
            for (int d = 0; d < digits; d++) f[d*7 +: 7] = 7'b1111110;
            return f;
        end
        for (int d = 0; d < digits; d++) begin
            pw = 10**d;
            if (blz && d > 0 && val < pw) f[d*7 +: 7] = 7'b1111111;
            else f[d*7 +: 7] = seg((val / pw) % 10);
        end
        return f;
    endfunction

    task automatic push_exp(input int v2, input int v1, input int v0, input logic [2:0] en);
        exp_t e;
        int v[3];
        logic [27:0] f;
        v = '{v0, v1, v2};
        for (int c = 0; c < 3; c++) begin
            f = exp_field(v[c], en[c], 4, 1'b1);  e.hex[c*28 +: 28]   = f;
            f = exp_field(v[c], en[c], 4, 1'b0);  e.hex_n[c*28 +: 28] = f;
            f = exp_field(v[c], en[c], 2, 1'b1);  e.hex_2[c*14 +: 14] = f[13:0];
            e.ovf[c]   = en[c] && (v[c] >= 10000);
            e.ovf_2[c] = en[c] && (v[c] >= 100);
        end
        sb.push_back(e);
    endtask

    task automatic drive_load(input int v2, input int v1, input int v0, input logic [2:0] en);
        ch_val = {10'(v2), 10'(v1), 10'(v0)};
        ch_en  = en;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int want_cycles);
        int n;
        exp_t e;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, n, want_cycles);
        check({tag, " done"}, done, 1'b1);
        check({tag, " done_other"}, {done_n, done_2}, 2'b11);
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s scoreboard: observed empty expected entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " hex"}, hex, e.hex);
            check({tag, " ovf"}, ovf, e.ovf);
            check({tag, " hex_nlz"}, hex_n, e.hex_n);
            check({tag, " hex_d2"}, hex_2, e.hex_2);
            check({tag, " ovf_d2"}, ovf_2, e.ovf_2);
        end
        @(negedge clk);
        check({tag, " done_pulse"}, done, 1'b0);
        check({tag, " busy_low"}, busy, 1'b0);
    endtask

    initial begin
        int extra;
        logic [27:0] old_ch2;

        rst_n  = 1'b0;
        load   = 1'b0;
        ch_val = '0;
        ch_en  = '0;
        repeat (3) @(negedge clk);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst hex", hex, {84{1'b1}});
        check("rst ovf", ovf, 3'b000);
        check("rst hex_d2", hex_2, {42{1'b1}});
        rst_n = 1'b1;
        @(negedge clk);

        push_exp(1023, 5, 63, 3'b111);
        drive_load(1023, 5, 63, 3'b111);
        wait_done("p1", 33);
        check("p1 ch0", hex[27:0],  {7'h7f, 7'h7f, 7'b0100000, 7'b0000110});
        check("p1 ch1", hex[55:28], {7'h7f, 7'h7f, 7'h7f, 7'b0100100});
        check("p1 ch2", hex[83:56], {7'b1001111, 7'b0000001, 7'b0010010, 7'b0000110});
        check("p1 nlz ch0", hex_n[27:0], {7'b0000001, 7'b0000001, 7'b0100000, 7'b0000110});
        check("p1 ovf", ovf, 3'b000);

        push_exp(99, 100, 0, 3'b111);
        drive_load(99, 100, 0, 3'b111);
        wait_done("p2", 33);
        check("p2 zero ch0", hex[27:0], {7'h7f, 7'h7f, 7'h7f, 7'b0000001});

        push_exp(5, 99, 100, 3'b111);
        drive_load(5, 99, 100, 3'b111);
        wait_done("p3", 33);
        check("p3 d2 ch0", hex_2[13:0], {7'b1111110, 7'b1111110});
        check("p3 d2 ch1", hex_2[27:14], {7'b0000100, 7'b0000100});
        check("p3 d2 ovf", ovf_2, 3'b001);

        old_ch2 = exp_field(5, 1'b1, 4, 1'b1);
        push_exp(700, 42, 9, 3'b101);
        drive_load(700, 42, 9, 3'b101);
        repeat (22) @(negedge clk);
        check("p4 busy_c23", busy, 1'b1);
        check("p4 ch2_hold", hex[83:56], old_ch2);
        wait_done("p4", 1);
        check("p4 ch1 blank", hex[55:28], {28{1'b1}});

        push_exp(1, 2, 3, 3'b111);
        drive_load(1, 2, 3, 3'b111);
        repeat (4) @(negedge clk);
        ch_val = {10'd4, 10'd5, 10'd6};
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        wait_done("p5", 28);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) extra++;
        end
        check("p5 no_restart", extra, 0);

        drive_load(7, 8, 9, 3'b111);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("p6 rst busy", busy, 1'b0);
        check("p6 rst done", done, 1'b0);
        check("p6 rst hex", hex, {84{1'b1}});
        check("p6 rst ovf", ovf, 3'b000);
        rst_n = 1'b1;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) extra++;
        end
        check("p6 no_done", extra, 0);

        push_exp(321, 0, 1000, 3'b111);
        drive_load(321, 0, 1000, 3'b111);
        wait_done("p7", 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
